// File: rtl/mem_stage.sv
// Memory/writeback stage: drives the data-memory bus, formats load data and the register write-back.
// Define MISALIGN_TRAP_EN to suppress misaligned LW/LH/LHU/SH accesses and pulse misalign instead.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_in,
    input  logic [31:0] store_data_in,
    input  logic [31:0] instruction_in,
    input  logic [31:0] PC_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] wdata,
    output logic        reg_wr,
    output logic        misalign
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQ_WAIT  = 2'd1;
    localparam logic [1:0] RESP_WAIT = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] load_q, load_d;

    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic        valid, is_load, is_store, is_jump, is_branch;
    logic        is_byte, is_half, misaligned, mem_ok;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata, load_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        unused_instr;

    assign opcode       = instruction_in[6:2];
    assign func3        = instruction_in[14:12];
    assign rd           = instruction_in[11:7];
    assign unused_instr = ^instruction_in[31:15];

    assign valid     = (instruction_in[1:0] == 2'b11);
    assign is_load   = valid && (opcode == 5'b00000);
    assign is_store  = valid && (opcode == 5'b01000);
    assign is_jump   = valid && ((opcode == 5'b11011) || (opcode == 5'b11001));
    assign is_branch = valid && (opcode == 5'b11000);
    assign is_byte   = (func3[1:0] == 2'b00);
    assign is_half   = (func3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    // Word stores are deliberately not trapped; only LW and halfword accesses are.
    assign misaligned = (is_load && !is_byte && !is_half && (alu_in[1:0] != 2'b00))
                     || ((is_load || is_store) && is_half && alu_in[0]);
`else
    assign misaligned = 1'b0;
`endif

    assign mem_ok   = (is_load || is_store) && !misaligned;
    assign misalign = misaligned && (state_q == IDLE);

    always_comb begin
        if (is_byte) begin
            lane_strb  = 4'b0001 << alu_in[1:0];
            lane_wdata = {4{store_data_in[7:0]}};
        end else if (is_half) begin
            lane_strb  = 4'b0011 << {alu_in[1], 1'b0};
            lane_wdata = {2{store_data_in[15:0]}};
        end else begin
            lane_strb  = 4'b1111;
            lane_wdata = store_data_in;
        end
    end

    assign ld_byte = load_q[{alu_in[1:0], 3'b000} +: 8];
    assign ld_half = alu_in[1] ? load_q[31:16] : load_q[15:0];

    always_comb begin
        if (is_byte) begin
            load_fmt = func3[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            load_fmt = func3[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end else begin
            load_fmt = load_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_ok && is_load) begin
                    dmem_req = 1'b1;
                    stall    = 1'b1;
                    state_d  = dmem_gnt ? RESP_WAIT : REQ_WAIT;
                end else if (mem_ok && is_store) begin
                    // Stores retire on grant; no response is awaited.
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                    stall    = !dmem_gnt;
                end
            end
            REQ_WAIT: begin
                dmem_req = 1'b1;
                stall    = 1'b1;
                if (dmem_gnt) state_d = RESP_WAIT;
            end
            RESP_WAIT: begin
                stall = 1'b1;
                if (dmem_rvalid) begin
                    load_d  = dmem_rdata;
                    state_d = DONE;
                end
            end
            // The load is still presented upstream here, so no request may be raised.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dmem_addr  = {alu_in[31:2], 2'b00};
    assign dmem_wstrb = dmem_req ? lane_strb : 4'b0000;
    assign dmem_wdata = dmem_we ? lane_wdata : 32'd0;

    assign wdata  = is_load ? load_fmt : (is_jump ? PC_in + 32'd4 : alu_in);
    assign reg_wr = valid && !is_store && !is_branch && (rd != 5'd0) && !stall && !misalign;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level reference model.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_in, store_data_in, instruction_in, PC_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall, reg_wr, misalign;
    logic [31:0] wdata;

    int n_vec = 0;
    int n_err = 0;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .alu_in         (alu_in),
        .store_data_in  (store_data_in),
        .instruction_in (instruction_in),
        .PC_in          (PC_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .wdata          (wdata),
        .reg_wr         (reg_wr),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] f3,
                                       input logic [4:0] rdi);
        return {17'd0, f3, rdi, op, 2'b11};
    endfunction

    // Reference: pick the addressed byte/half out of the word and extend it arithmetically.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        if (f3[1:0] == 2'b00) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else if (f3[1:0] == 2'b01) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2,
                           input logic [31:0] pc, input int g, input int r,
                           input logic [31:0] word);
        logic [4:0]  op;
        logic [2:0]  f3;
        logic        vld, ld, st, jmp, br, trap, exp_wr;
        logic [3:0]  es;
        logic [31:0] ew, base;
        int          sz;
        op   = ins[6:2];
        f3   = ins[14:12];
        vld  = (ins[1:0] == 2'b11);
        ld   = vld && (op == 5'b00000);
        st   = vld && (op == 5'b01000);
        jmp  = vld && ((op == 5'b11011) || (op == 5'b11001));
        br   = vld && (op == 5'b11000);
        sz   = 1 << f3[1:0];
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((ld || (st && sz == 2)) && (alu % sz != 0)) trap = 1'b1;
`endif
        exp_wr = vld && !st && !br && (ins[11:7] != 5'd0);
        instruction_in = ins;
        alu_in         = alu;
        store_data_in  = rs2;
        PC_in          = pc;
        dmem_gnt       = 1'b0;
        dmem_rvalid    = 1'b0;
        dmem_rdata     = $urandom;
        if (trap) begin
            @(negedge clk);
            check_eq("trap_misalign", misalign, 1);
            check_eq("trap_req", dmem_req, 0);
            check_eq("trap_stall", stall, 0);
            check_eq("trap_regwr", reg_wr, 0);
            step();
        end else if (ld) begin
            for (int c = 0; c <= g + r; c++) begin
                dmem_gnt = (c == g);
                if (c == g + r) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = word;
                end else if (c <= g) begin
                    dmem_rvalid = 1'($urandom_range(0, 1));
                    dmem_rdata  = $urandom;
                end else begin
                    dmem_rvalid = 1'b0;
                end
                @(negedge clk);
                check_eq("ld_req", dmem_req, (c <= g));
                check_eq("ld_we", dmem_we, 0);
                check_eq("ld_stall", stall, 1);
                check_eq("ld_regwr", reg_wr, 0);
                if (c <= g) check_eq("ld_addr", dmem_addr, alu & ~32'd3);
                step();
            end
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = $urandom;
            @(negedge clk);
            check_eq("done_stall", stall, 0);
            check_eq("done_req", dmem_req, 0);
            check_eq("done_wdata", wdata, fmt_load(f3, alu, word));
            check_eq("done_regwr", reg_wr, exp_wr);
            check_eq("done_misalign", misalign, 0);
            step();
        end else if (st) begin
            // Byte enables cover the naturally aligned sz-byte block holding the address.
            base = alu & ~(sz - 1);
            es   = 4'b0000;
            for (int k = 0; k < sz; k++) es[base[1:0] + k] = 1'b1;
            if (sz == 1) ew = (rs2 & 32'hFF) * 32'h01010101;
            else if (sz == 2) ew = (rs2 & 32'hFFFF) * 32'h00010001;
            else ew = rs2;
            for (int c = 0; c <= g; c++) begin
                dmem_gnt = (c == g);
                @(negedge clk);
                check_eq("st_req", dmem_req, 1);
                check_eq("st_we", dmem_we, 1);
                check_eq("st_addr", dmem_addr, alu & ~32'd3);
                check_eq("st_wstrb", dmem_wstrb, es);
                check_eq("st_wdata", dmem_wdata, ew);
                check_eq("st_stall", stall, (c != g));
                check_eq("st_regwr", reg_wr, 0);
                step();
            end
            dmem_gnt = 1'b0;
        end else begin
            @(negedge clk);
            check_eq("op_req", dmem_req, 0);
            check_eq("op_stall", stall, 0);
            check_eq("op_regwr", reg_wr, exp_wr);
            check_eq("op_misalign", misalign, 0);
            if (vld) check_eq("op_wdata", wdata, jmp ? pc + 32'd4 : alu);
            step();
        end
    endtask

    initial begin
        logic [31:0] ins, alu, rnd;
        logic [2:0]  f3;
        logic [4:0]  rdi, op;
        int          kind;
        logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [4:0]  op_tbl [4] = '{5'b11011, 5'b11001, 5'b11000, 5'b00100};

        rst            = 1'b0;
        alu_in         = 32'h0;
        store_data_in  = 32'h0;
        instruction_in = 32'h0;
        PC_in          = 32'h0;
        dmem_gnt       = 1'b0;
        dmem_rvalid    = 1'b1;
        dmem_rdata     = 32'hA5A5A5A5;
        step();
        step();
        @(negedge clk);
        check_eq("rst_req", dmem_req, 0);
        check_eq("rst_we", dmem_we, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_regwr", reg_wr, 0);
        check_eq("rst_misalign", misalign, 0);
        rst = 1'b1;
        step();
        @(negedge clk);
        check_eq("late_rvalid_stall", stall, 0);
        step();

        run_txn(mk(5'b01000, 3'd2, 5'd0), 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 32'h0);
        run_txn(mk(5'b00000, 3'd0, 5'd5), 32'h103, 32'h0, 32'h0, 2, 3, 32'h80123456);
        run_txn(mk(5'b00000, 3'd5, 5'd7), 32'h102, 32'h0, 32'h0, 0, 1, 32'h80010000);
        run_txn(mk(5'b01000, 3'd1, 5'd0), 32'h102, 32'h1234ABCD, 32'h0, 1, 1, 32'h0);
        run_txn(mk(5'b11011, 3'd0, 5'd1), 32'h0, 32'h0, 32'h200, 0, 1, 32'h0);
        run_txn(mk(5'b00100, 3'd0, 5'd0), 32'h77, 32'h0, 32'h0, 0, 1, 32'h0);
        run_txn(mk(5'b00000, 3'd2, 5'd9), 32'h101, 32'h0, 32'h0, 0, 1, 32'hCAFEF00D);
        run_txn(mk(5'b11111, 3'd7, 5'd0), 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFC, 0, 1, 32'h0);
        run_txn(mk(5'b11001, 3'd0, 5'd4), 32'h0, 32'h0, 32'hFFFFFFFC, 0, 1, 32'h0);

        // Reset while waiting for the response: the late rvalid must not cause a write-back.
        instruction_in = mk(5'b00000, 3'd2, 5'd5);
        alu_in         = 32'h40;
        dmem_gnt       = 1'b1;
        dmem_rvalid    = 1'b0;
        step();
        dmem_gnt       = 1'b0;
        rst            = 1'b0;
        instruction_in = 32'h0;
        step();
        rst            = 1'b1;
        dmem_rvalid    = 1'b1;
        dmem_rdata     = 32'h11223344;
        @(negedge clk);
        check_eq("rstmid_stall", stall, 0);
        check_eq("rstmid_regwr", reg_wr, 0);
        check_eq("rstmid_req", dmem_req, 0);
        step();
        dmem_rvalid = 1'b0;
        run_txn(mk(5'b00100, 3'd0, 5'd3), 32'h55, 32'h0, 32'h0, 0, 1, 32'h0);

        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 4);
            rdi  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            alu  = $urandom;
            case (kind)
                0: begin op = 5'b00000; f3 = ld_f3[$urandom_range(0, 4)]; end
                1: begin op = 5'b01000; f3 = 3'($urandom_range(0, 2)); end
                2: begin op = op_tbl[$urandom_range(0, 3)]; f3 = 3'($urandom); end
                default: begin op = 5'($urandom_range(0, 1) * 8); f3 = 3'($urandom); end
            endcase
            if (op == 5'b01000 && f3 == 3'd2) alu[1:0] = 2'b00;
            rnd = $urandom;
            ins = {rnd[31:15], f3, rdi, op, 2'b11};
            if (kind == 4) ins[1:0] = 2'($urandom_range(0, 2));
            run_txn(ins, alu, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
                    $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
